// File: rtl/async_wr_ptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser, and registered full / almost_full / level / overflow.
module async_wr_ptr_ctrl #(
  parameter int ADDR_SIZE    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = (1 << ADDR_SIZE) - 2
) (
  input  logic                 wr_clk,
  input  logic                 wr_rstn,
  input  logic                 wr_en,
  input  logic                 clr_ovf,
  input  logic [ADDR_SIZE:0]   rd_addr_gray,
  output logic                 wr_accept,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE:0]   wr_addr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 overflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [SYNC_STAGES-1:0][ADDR_SIZE:0] r_sync;
  logic [ADDR_SIZE:0] r_wr_bin;
  logic [ADDR_SIZE:0] r_wr_gray;
  logic [ADDR_SIZE:0] r_level;
  logic               r_full;
  logic               r_afull;
  logic               r_ovf;

  logic [ADDR_SIZE:0] w_rd_gray_s;
  logic [ADDR_SIZE:0] w_rd_bin_s;
  logic [ADDR_SIZE:0] w_wr_bin_next;
  logic [ADDR_SIZE:0] w_wr_gray_next;
  logic [ADDR_SIZE:0] w_level_next;
  logic [ADDR_SIZE:0] w_full_pattern;
  logic               w_full_next;
  logic               w_afull_next;
  logic               w_ovf_set;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // the synchroniser chain is reset too, otherwise a stale read pointer could fake room.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= rd_addr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_rd_gray_s = r_sync[SYNC_STAGES-1];

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_rd_bin_s = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      w_rd_bin_s[i] = ^(w_rd_gray_s >> i);
    end
  end

  assign wr_accept      = wr_en & ~r_full;
  assign w_wr_bin_next  = r_wr_bin + {{ADDR_SIZE{1'b0}}, wr_accept};
  assign w_wr_gray_next = w_wr_bin_next ^ (w_wr_bin_next >> 1);
  assign w_level_next   = w_wr_bin_next - w_rd_bin_s;

  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
  assign w_full_pattern = {~w_rd_gray_s[ADDR_SIZE:ADDR_SIZE-1], w_rd_gray_s[ADDR_SIZE-2:0]};
  assign w_full_next    = (w_wr_gray_next == w_full_pattern);
  assign w_afull_next   = (w_level_next >= AFULL_LVL);
  assign w_ovf_set      = wr_en & r_full;

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_level   <= '0;
    end else begin
      r_wr_bin  <= w_wr_bin_next;
      r_wr_gray <= w_wr_gray_next;
      r_full    <= w_full_next;
      r_afull   <= w_afull_next;
      r_level   <= w_level_next;
    end
  end

  // Sticky overflow; a set in the same cycle as a clear takes priority.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign wr_addr      = r_wr_bin[ADDR_SIZE-1:0];
  assign wr_addr_gray = r_wr_gray;
  assign full         = r_full;
  assign almost_full  = r_afull;
  assign wr_level     = r_level;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_async_wr_ptr_ctrl.sv
// Directed bench for async_wr_ptr_ctrl: fill/drain/overflow vector table, mid-operation
// reset, wrap-around scoreboard, and a deeper-synchroniser instance.
module tb_async_wr_ptr_ctrl;

  logic wr_clk = 1'b0;
  logic wr_rstn;
  always #5 wr_clk = ~wr_clk;

  // Instance A: ADDR_SIZE=2, SYNC_STAGES=2, AFULL_THRESH=3
  logic       wr_en, clr_ovf;
  logic [2:0] rd_addr_gray;
  logic       wr_accept, full, almost_full, overflow;
  logic [1:0] wr_addr;
  logic [2:0] wr_addr_gray, wr_level;

  // Instance B: ADDR_SIZE=3, SYNC_STAGES=4, default AFULL_THRESH (6)
  logic       wr_en4, clr_ovf4;
  logic [3:0] rd_addr_gray4;
  logic       wr_accept4, full4, almost_full4, overflow4;
  logic [2:0] wr_addr4;
  logic [3:0] wr_addr_gray4, wr_level4;

  async_wr_ptr_ctrl #(.ADDR_SIZE(2), .SYNC_STAGES(2), .AFULL_THRESH(3)) u_dut (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .wr_en(wr_en), .clr_ovf(clr_ovf),
    .rd_addr_gray(rd_addr_gray), .wr_accept(wr_accept), .wr_addr(wr_addr),
    .wr_addr_gray(wr_addr_gray), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow)
  );

  async_wr_ptr_ctrl #(.ADDR_SIZE(3), .SYNC_STAGES(4)) u_dut4 (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .wr_en(wr_en4), .clr_ovf(clr_ovf4),
    .rd_addr_gray(rd_addr_gray4), .wr_accept(wr_accept4), .wr_addr(wr_addr4),
    .wr_addr_gray(wr_addr_gray4), .full(full4), .almost_full(almost_full4),
    .wr_level(wr_level4), .overflow(overflow4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] gray3(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  typedef struct {
    logic       wr_en;
    logic       clr_ovf;
    logic [2:0] rd_gray;
    logic       exp_accept;
    logic [2:0] exp_level;
    logic       exp_full;
    logic       exp_afull;
    logic       exp_ovf;
    logic [2:0] exp_gray;
    logic [1:0] exp_addr;
  } vec_t;

  vec_t vecs[15];

  task automatic reset_dut();
    wr_rstn = 1'b0;
    wr_en = 0; clr_ovf = 0; rd_addr_gray = '0;
    wr_en4 = 0; clr_ovf4 = 0; rd_addr_gray4 = '0;
    repeat (2) @(posedge wr_clk);
    #1 wr_rstn = 1'b1;
  endtask

  initial begin
    // en clr rd   acc lvl full af ovf gray addr
    vecs[0]  = '{1, 0, 3'b000, 1, 1, 0, 0, 0, 3'b001, 1};
    vecs[1]  = '{1, 0, 3'b000, 1, 2, 0, 0, 0, 3'b011, 2};
    vecs[2]  = '{1, 0, 3'b000, 1, 3, 0, 1, 0, 3'b010, 3};
    vecs[3]  = '{1, 0, 3'b000, 1, 4, 1, 1, 0, 3'b110, 0};
    vecs[4]  = '{1, 0, 3'b000, 0, 4, 1, 1, 1, 3'b110, 0};
    vecs[5]  = '{0, 0, 3'b001, 0, 4, 1, 1, 1, 3'b110, 0};
    vecs[6]  = '{0, 0, 3'b001, 0, 4, 1, 1, 1, 3'b110, 0};
    vecs[7]  = '{0, 0, 3'b001, 0, 3, 0, 1, 1, 3'b110, 0};
    vecs[8]  = '{0, 1, 3'b001, 0, 3, 0, 1, 0, 3'b110, 0};
    vecs[9]  = '{1, 0, 3'b001, 1, 4, 1, 1, 0, 3'b111, 1};
    vecs[10] = '{1, 1, 3'b001, 0, 4, 1, 1, 1, 3'b111, 1};
    vecs[11] = '{0, 1, 3'b001, 0, 4, 1, 1, 0, 3'b111, 1};
    vecs[12] = '{0, 0, 3'b011, 0, 4, 1, 1, 0, 3'b111, 1};
    vecs[13] = '{0, 0, 3'b011, 0, 4, 1, 1, 0, 3'b111, 1};
    vecs[14] = '{0, 0, 3'b011, 0, 3, 0, 1, 0, 3'b111, 1};

    reset_dut();
    check("rst_level", 32'(wr_level), 0);
    check("rst_gray", 32'(wr_addr_gray), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_flags", {full, almost_full, overflow}, 0);

    // Fill, drain release and overflow set/clear
    for (int i = 0; i < 15; i++) begin
      wr_en = vecs[i].wr_en; clr_ovf = vecs[i].clr_ovf; rd_addr_gray = vecs[i].rd_gray;
      #1 check($sformatf("v%0d_accept", i), 32'(wr_accept), 32'(vecs[i].exp_accept));
      @(posedge wr_clk); #1;
      check($sformatf("v%0d_level", i), 32'(wr_level), 32'(vecs[i].exp_level));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("v%0d_afull", i), 32'(almost_full), 32'(vecs[i].exp_afull));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("v%0d_gray", i), 32'(wr_addr_gray), 32'(vecs[i].exp_gray));
      check($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
    end

    // Mid-operation asynchronous reset at level 3
    wr_en = 0; clr_ovf = 0;
    #2 wr_rstn = 1'b0;
    rd_addr_gray = '0;
    #1;
    check("mrst_level", 32'(wr_level), 0);
    check("mrst_gray", 32'(wr_addr_gray), 0);
    check("mrst_addr", 32'(wr_addr), 0);
    check("mrst_flags", {full, almost_full, overflow}, 0);
    #2 wr_rstn = 1'b1;
    wr_en = 1;
    #1 check("mrst_accept", 32'(wr_accept), 1);
    @(posedge wr_clk); #1;
    check("mrst_first_gray", 32'(wr_addr_gray), 32'b001);
    check("mrst_first_level", 32'(wr_level), 1);
    wr_en = 0;

    // Wrap-around with a model reader and a 3-edge read-lag scoreboard
    reset_dut();
    begin
      int wb, rp, r_m1, r_m2, accepted, wraps, msb_toggles, level;
      logic full_m, exp_acc;
      logic [2:0] prev_gray;
      logic [1:0] prev_addr;
      wb = 0; rp = 0; r_m1 = 0; r_m2 = 0; accepted = 0; wraps = 0; msb_toggles = 0;
      full_m = 0; prev_gray = '0; prev_addr = '0;
      for (int cyc = 0; cyc < 200 && accepted < 20; cyc++) begin
        if ((cyc % 3) != 0 && rp < wb) rp++;
        rd_addr_gray = gray3(rp);
        wr_en = 1;
        exp_acc = ~full_m;
        #1 check($sformatf("wrap%0d_accept", cyc), 32'(wr_accept), 32'(exp_acc));
        @(posedge wr_clk); #1;
        if (exp_acc) begin
          wb++;
          accepted++;
        end
        level  = wb - r_m2;
        full_m = (level == 4);
        r_m2 = r_m1;
        r_m1 = rp;
        check($sformatf("wrap%0d_level", cyc), 32'(wr_level), 32'(level));
        check($sformatf("wrap%0d_full", cyc), 32'(full), 32'(full_m));
        check($sformatf("wrap%0d_afull", cyc), 32'(almost_full), 32'(level >= 3));
        check($sformatf("wrap%0d_addr", cyc), 32'(wr_addr), 32'(wb % 4));
        check($sformatf("wrap%0d_gray", cyc), 32'(wr_addr_gray), 32'(gray3(wb)));
        check($sformatf("wrap%0d_onebit", cyc), 32'($countones(wr_addr_gray ^ prev_gray)),
              32'(exp_acc));
        if (prev_addr == 2'd3 && wr_addr == 2'd0) wraps++;
        if (prev_gray[2] != wr_addr_gray[2]) msb_toggles++;
        prev_gray = wr_addr_gray;
        prev_addr = wr_addr;
      end
      check("wrap_accepted", 32'(accepted), 20);
      check("wrap_count", 32'(wraps), 5);
      check("wrap_msb_toggles", 32'(msb_toggles), 5);
      wr_en = 0;
    end

    // Deeper synchroniser: full at 8 writes, read clears full only on the 5th edge
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      wr_en4 = 1;
      #1 check($sformatf("s4_w%0d_accept", i), 32'(wr_accept4), 32'(i < 8));
      @(posedge wr_clk); #1;
      check($sformatf("s4_w%0d_level", i), 32'(wr_level4), 32'(i < 8 ? i + 1 : 8));
      check($sformatf("s4_w%0d_full", i), 32'(full4), 32'(i >= 7));
    end
    check("s4_overflow", 32'(overflow4), 1);
    wr_en4 = 0;
    rd_addr_gray4 = 4'b0001;
    for (int e = 1; e <= 5; e++) begin
      @(posedge wr_clk); #1;
      check($sformatf("s4_r%0d_full", e), 32'(full4), 32'(e < 5));
      check($sformatf("s4_r%0d_level", e), 32'(wr_level4), 32'(e < 5 ? 8 : 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
